// File: rtl/hidden_step_sched.sv
// Time-step scheduler for one shared pipelined hidden neuron: issues H evaluations per
// step, collects the narrowed results and commits them. HSCHED_SAT_EN selects saturation.
module hidden_step_sched #(
   parameter int dataWidth  = 5,
   parameter int fracWidth  = 2,
   parameter int hiddenSize = 3,
   parameter int neuronLat  = 4,
   parameter int timeSteps  = 8,
   localparam int AW = (hiddenSize > 1) ? $clog2(hiddenSize) : 1,
   localparam int SW = $clog2(timeSteps) + 1,
   localparam int RW = 2 * dataWidth + 1,
   localparam int VW = dataWidth * hiddenSize
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   output logic          busy,
   output logic          issue_vld,
   output logic [AW-1:0] w_addr,
   output logic [VW-1:0] nrn_hid,
   input  logic [RW-1:0] nrn_final,
   output logic [VW-1:0] h_out,
   output logic [SW-1:0] step_idx,
   output logic          step_done,
   output logic          done
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ISSUE  = 2'd1,
      S_DRAIN  = 2'd2,
      S_COMMIT = 2'd3
   } state_t;

   localparam int RES_FRAC = fracWidth;
   localparam int HID_FRAC = fracWidth;
   localparam logic [neuronLat-1:0] TAG_LAST_ONLY = neuronLat'(1) << (neuronLat - 1);

   // Result and hidden state share the binary point, so the alignment shift is zero.
   function automatic logic [dataWidth-1:0] narrow(input logic signed [RW-1:0] v);
      logic signed [RW-1:0] aligned;
      aligned = v >>> (RES_FRAC - HID_FRAC);
`ifdef HSCHED_SAT_EN
      if (aligned > RW'((1 <<< (dataWidth - 1)) - 1)) begin
         return {1'b0, {(dataWidth - 1){1'b1}}};
      end else if (aligned < -RW'(1 <<< (dataWidth - 1))) begin
         return {1'b1, {(dataWidth - 1){1'b0}}};
      end else begin
         return dataWidth'(aligned);
      end
`else
      return dataWidth'(aligned);
`endif
   endfunction

   state_t                state_q, state_d;
   logic [AW-1:0]         n_q, n_d;
   logic [SW-1:0]         step_q, step_d;
   logic [VW-1:0]         h_state_q, h_state_d;
   logic [VW-1:0]         h_next_q, h_next_d;
   logic [neuronLat-1:0]  tag_vld_q, tag_vld_d;
   logic [AW-1:0]         tag_idx_q [neuronLat];
   logic [AW-1:0]         tag_idx_d [neuronLat];
   logic                  busy_q, busy_d;
   logic                  issue_vld_q, issue_vld_d;
   logic [AW-1:0]         w_addr_q, w_addr_d;
   logic                  step_done_q, step_done_d;
   logic                  done_q, done_d;

   // Next-state, tag pipe shift, result capture and registered-output decode.
   always_comb begin
      state_d     = state_q;
      n_d         = n_q;
      step_d      = step_q;
      h_state_d   = h_state_q;
      h_next_d    = h_next_q;
      step_done_d = 1'b0;
      done_d      = 1'b0;

      for (int k = neuronLat - 1; k > 0; k--) begin
         tag_vld_d[k] = tag_vld_q[k-1];
         tag_idx_d[k] = tag_idx_q[k-1];
      end
      tag_vld_d[0] = (state_q == S_ISSUE);
      tag_idx_d[0] = n_q;

      if (tag_vld_q[neuronLat-1]) begin
         h_next_d[tag_idx_q[neuronLat-1]*dataWidth +: dataWidth] = narrow(nrn_final);
      end else begin
         h_next_d = h_next_q;
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d   = S_ISSUE;
               h_state_d = '0;
               step_d    = '0;
               n_d       = '0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ISSUE: begin
            if (n_q == AW'(hiddenSize - 1)) begin
               state_d = S_DRAIN;
            end else begin
               n_d = n_q + AW'(1);
            end
         end
         S_DRAIN: begin
            // Only the final tag left at the capture stage: the pipe is empty after this edge.
            if (tag_vld_q == TAG_LAST_ONLY) begin
               state_d = S_COMMIT;
            end else begin
               state_d = S_DRAIN;
            end
         end
         S_COMMIT: begin
            h_state_d   = h_next_q;
            step_done_d = 1'b1;
            if (step_q == SW'(timeSteps - 1)) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end else begin
               step_d  = step_q + SW'(1);
               n_d     = '0;
               state_d = S_ISSUE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d      = (state_d != S_IDLE);
      issue_vld_d = (state_d == S_ISSUE);
      w_addr_d    = n_d;
   end

   // State and output registers; reset discards any in-flight tags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         n_q         <= '0;
         step_q      <= '0;
         h_state_q   <= '0;
         h_next_q    <= '0;
         tag_vld_q   <= '0;
         for (int k = 0; k < neuronLat; k++) begin
            tag_idx_q[k] <= '0;
         end
         busy_q      <= 1'b0;
         issue_vld_q <= 1'b0;
         w_addr_q    <= '0;
         step_done_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         n_q         <= n_d;
         step_q      <= step_d;
         h_state_q   <= h_state_d;
         h_next_q    <= h_next_d;
         tag_vld_q   <= tag_vld_d;
         for (int k = 0; k < neuronLat; k++) begin
            tag_idx_q[k] <= tag_idx_d[k];
         end
         busy_q      <= busy_d;
         issue_vld_q <= issue_vld_d;
         w_addr_q    <= w_addr_d;
         step_done_q <= step_done_d;
         done_q      <= done_d;
      end
   end

   assign busy      = busy_q;
   assign issue_vld = issue_vld_q;
   assign w_addr    = w_addr_q;
   assign nrn_hid   = h_state_q;
   assign h_out     = h_state_q;
   assign step_idx  = step_q;
   assign step_done = step_done_q;
   assign done      = done_q;

endmodule

// File: tb/tb_hidden_step_sched.sv
// Bench for hidden_step_sched: emulates the pipelined neuron and predicts every output
// per cycle from a step-level model of the hidden-state recurrence.
module tb_hidden_step_sched;
   localparam int DW = 5;
   localparam int FW = 2;
   localparam int H  = 3;
   localparam int L  = 4;
   localparam int T  = 2;
   localparam int P  = H + L + 1;
   localparam int RW = 2 * DW + 1;
   localparam int AW = 2;
   localparam int SW = 2;
   localparam int VW = DW * H;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          busy;
   logic          issue_vld;
   logic [AW-1:0] w_addr;
   logic [VW-1:0] nrn_hid;
   logic [RW-1:0] nrn_final;
   logic [VW-1:0] h_out;
   logic [SW-1:0] step_idx;
   logic          step_done;
   logic          done;

   int tests_run    = 0;
   int tests_failed = 0;
   int mode;
   int wt [H][H];
   int bias [H];
   logic [VW-1:0] hs [T+1];
   int dl_val [L+1];
   bit dl_v [L+1];

   always #5 clk = ~clk;

   hidden_step_sched #(
      .dataWidth(DW), .fracWidth(FW), .hiddenSize(H), .neuronLat(L), .timeSteps(T)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .issue_vld(issue_vld),
      .w_addr(w_addr), .nrn_hid(nrn_hid), .nrn_final(nrn_final), .h_out(h_out),
      .step_idx(step_idx), .step_done(step_done), .done(done)
   );

   // Neuron behaviour: 0 -> 2*i+1, 1 -> constant 40, else weighted sum plus bias.
   function automatic int nrn_fn(int i, logic [VW-1:0] hv);
      int acc;
      if (mode == 0) return 2 * i + 1;
      if (mode == 1) return 40;
      acc = bias[i];
      for (int j = 0; j < H; j++) acc += wt[i][j] * int'($signed(hv[j*DW +: DW]));
      return acc;
   endfunction

   function automatic logic [DW-1:0] narrow_ref(int v);
      int mx;
      int r;
      mx = (1 << (DW - 1)) - 1;
`ifdef HSCHED_SAT_EN
      if (v > mx) return DW'(mx);
      if (v < -mx - 1) return DW'(-mx - 1);
      return DW'(v);
`else
      r = ((v % (1 << DW)) + (1 << DW)) % (1 << DW);
      return DW'(r);
`endif
   endfunction

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Neuron emulator: result appears L cycles after its issue; junk when nothing is due.
   initial begin
      nrn_final = '0;
      for (int k = 0; k <= L; k++) begin
         dl_v[k]   = 1'b0;
         dl_val[k] = 0;
      end
      forever begin
         @(negedge clk);
         for (int k = L; k > 0; k--) begin
            dl_v[k]   = dl_v[k-1];
            dl_val[k] = dl_val[k-1];
         end
         dl_v[0]   = issue_vld;
         dl_val[0] = issue_vld ? nrn_fn(int'(w_addr), nrn_hid) : 0;
         nrn_final = dl_v[L] ? RW'(dl_val[L]) : RW'($urandom);
      end
   end

   // Expects start to have been raised at the previous negedge. Checks every cycle of a run.
   task automatic run_checked(input int busy_start_j, input bit chain, input int abort_j);
      int t;
      int off;
      bit in_run;
      hs[0] = '0;
      for (int s = 0; s < T; s++)
         for (int i = 0; i < H; i++) hs[s+1][i*DW +: DW] = narrow_ref(nrn_fn(i, hs[s]));
      for (int j = 0; j <= T * P; j++) begin
         @(negedge clk);
         t      = j / P;
         off    = j % P;
         in_run = (j < T * P);
         check_eq("busy", busy, in_run);
         check_eq("issue_vld", issue_vld, in_run && off < H);
         if (in_run && off < H) begin
            check_eq("w_addr", w_addr, off);
            check_eq("nrn_hid", nrn_hid, hs[t]);
         end
         check_eq("step_done", step_done, j > 0 && off == 0);
         check_eq("done", done, j == T * P);
         check_eq("h_out", h_out, hs[j / P]);
         check_eq("step_idx", step_idx, (j / P < T - 1) ? j / P : T - 1);
         start = (j == busy_start_j) || (chain && j == T * P);
         if (j == abort_j) begin
            rst = 1'b1;
            return;
         end
      end
   endtask

   task automatic check_quiet(input int n);
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         check_eq("quiet_busy", busy, 0);
         check_eq("quiet_issue", issue_vld, 0);
         check_eq("quiet_step_done", step_done, 0);
         check_eq("quiet_h_out", h_out, hs[T]);
      end
   endtask

   task automatic randomize_weights();
      for (int i = 0; i < H; i++) begin
         bias[i] = int'($urandom_range(63)) - 32;
         for (int j = 0; j < H; j++) wt[i][j] = int'($urandom_range(31)) - 16;
      end
   endtask

   initial begin
      logic [VW-1:0] ref_531;
      logic [VW-1:0] ref_big;
      ref_531 = {5'd5, 5'd3, 5'd1};
`ifdef HSCHED_SAT_EN
      ref_big = {3{5'd15}};
`else
      ref_big = {3{5'd8}};
`endif
      rst   = 1'b1;
      start = 1'b0;
      mode  = 0;
      randomize_weights();
      repeat (3) @(negedge clk);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_issue", issue_vld, 0);
      check_eq("rst_w_addr", w_addr, 0);
      check_eq("rst_h_out", h_out, 0);
      check_eq("rst_step_idx", step_idx, 0);
      check_eq("rst_step_done", step_done, 0);
      check_eq("rst_done", done, 0);
      rst = 1'b0;

      // Reset in the middle of ISSUE.
      @(negedge clk);
      start = 1'b1;
      run_checked(-1, 1'b0, 1);
      @(negedge clk);
      check_eq("t1_busy", busy, 0);
      check_eq("t1_issue", issue_vld, 0);
      check_eq("t1_h_out", h_out, 0);
      rst = 1'b0;
      hs[T] = '0;
      check_quiet(10);

      // Plain run with the 2*i+1 neuron.
      @(negedge clk);
      start = 1'b1;
      run_checked(-1, 1'b0, -1);
      check_eq("t2_h_out_const", h_out, ref_531);

      // Out-of-range neuron result.
      mode = 1;
      @(negedge clk);
      start = 1'b1;
      run_checked(-1, 1'b0, -1);
      check_eq("t4_narrow_const", h_out, ref_big);

      // Start while busy is ignored; start in the done cycle chains a new run.
      mode = 2;
      randomize_weights();
      @(negedge clk);
      start = 1'b1;
      run_checked(5, 1'b1, -1);
      run_checked(-1, 1'b0, -1);
      check_quiet(5);

      // Reset during DRAIN with two tags in flight, then a clean run.
      mode = 0;
      @(negedge clk);
      start = 1'b1;
      run_checked(-1, 1'b0, 5);
      @(negedge clk);
      check_eq("t6_busy", busy, 0);
      check_eq("t6_h_out", h_out, 0);
      rst = 1'b0;
      @(negedge clk);
      start = 1'b1;
      run_checked(-1, 1'b0, -1);
      check_eq("t6_h_out_const", h_out, ref_531);

      // Random recurrences.
      mode = 2;
      for (int r = 0; r < 6; r++) begin
         randomize_weights();
         @(negedge clk);
         start = 1'b1;
         run_checked(-1, 1'b0, -1);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
